// File: rtl/uart_pkg.sv
// Shared types and defaults for the P03 UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_rx_state_e;

  localparam int UART_CLK_FREQ   = 50_000_000;
  localparam int UART_BAUD       = 115200;
  localparam int UART_DATA_WIDTH = 8;

  // Number of system clocks per bit on the line (integer division).
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so the idle-high line never looks like a start bit out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  // Shift the raw line through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: deframes start, data, optional parity and stop
// bits from the synchronized line and pulses rx_interrupt once per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ,
  parameter int BAUD       = UART_BAUD,
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_interrupt,
  output logic                  parity_error,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CNT_W      = $clog2(BIT_CYCLES);
  localparam int IDX_W      = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  logic                  rx_s;
  uart_rx_state_e        state;
  uart_rx_state_e        state_next;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bad;
  logic                  cnt_clear;
  logic                  shift_en;
  logic                  parity_take;
  logic                  stop_take;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s)
  );

  // State register; a mid-frame reset simply drops back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and per-cycle sample strobes.
  always_comb begin
    state_next  = state;
    cnt_clear   = 1'b0;
    shift_en    = 1'b0;
    parity_take = 1'b0;
    stop_take   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_clear  = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_clear  = 1'b1;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clear = 1'b1;
          shift_en  = 1'b1;
          if (bit_idx == IDX_LAST) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_clear   = 1'b1;
          parity_take = 1'b1;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clear  = 1'b1;
          stop_take  = 1'b1;
          state_next = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit-period counter, parked at zero whenever no frame timing is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            cnt <= '0;
    else if (cnt_clear || state == IDLE || state == WAIT_HIGH) cnt <= '0;
    else                                                 cnt <= cnt + 1'b1;
  end

  // Shift register, bit index and parity check for the frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg  <= '0;
      bit_idx    <= '0;
      parity_bad <= 1'b0;
    end else begin
      if (state == START) begin
        bit_idx    <= '0;
        parity_bad <= 1'b0;
      end
      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
        bit_idx   <= bit_idx + 1'b1;
      end
      if (parity_take) parity_bad <= ((^shift_reg) ^ rx_s) != 1'(PARITY_ODD);
    end
  end

  // Registered outputs, updated only when a stop bit is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data      <= '0;
      rx_interrupt <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_interrupt <= stop_take;
      if (stop_take) begin
        rx_data      <= shift_reg;
        parity_error <= parity_bad;
        frame_error  <= ~rx_s;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 instance and an 8E1 instance at
// 10 clocks per bit, with hand-computed expectations.
module tb_uart_rx;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_p = 1'b1;

  logic [7:0] data_a, data_p;
  logic       irq_a, irq_p;
  logic       pe_a, pe_p;
  logic       fe_a, fe_p;
  logic       busy_a, busy_p;

  int checks   = 0;
  int failures = 0;

  int   cycle        = 0;
  int   pulses_a     = 0;
  int   pulses_p     = 0;
  int   last_pulse_a = 0;
  int   prev_pulse_a = 0;
  logic irq_a_d      = 1'b0;
  logic busy_after_a = 1'b1;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .DATA_WIDTH (8),
    .PARITY_EN  (0),
    .PARITY_ODD (0)
  ) dut_a (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx_a),
    .rx_data      (data_a),
    .rx_interrupt (irq_a),
    .parity_error (pe_a),
    .frame_error  (fe_a),
    .busy         (busy_a)
  );

  uart_rx #(
    .CLK_FREQ   (1_000_000),
    .BAUD       (100_000),
    .DATA_WIDTH (8),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut_p (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx_p),
    .rx_data      (data_p),
    .rx_interrupt (irq_p),
    .parity_error (pe_p),
    .frame_error  (fe_p),
    .busy         (busy_p)
  );

  // Count interrupt pulses, note when they occur and what busy does after.
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (irq_a_d) busy_after_a = busy_a;
    if (irq_a) begin
      pulses_a     = pulses_a + 1;
      prev_pulse_a = last_pulse_a;
      last_pulse_a = cycle;
    end
    irq_a_d = irq_a;
    if (irq_p) pulses_p = pulses_p + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected)
    else begin
      failures = failures + 1;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic hold_a(input logic value, input int n);
    rx_a = value;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_p(input logic value, input int n);
    rx_p = value;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] data, input logic stop);
    hold_a(1'b0, 10);
    for (int i = 0; i < 8; i++) hold_a(data[i], 10);
    hold_a(stop, 10);
  endtask

  task automatic send_p(input logic [7:0] data, input logic par);
    hold_p(1'b0, 10);
    for (int i = 0; i < 8; i++) hold_p(data[i], 10);
    hold_p(par, 10);
    hold_p(1'b1, 10);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_output("reset_data",  32'(data_a), 32'h0);
    check_output("reset_irq",   32'(irq_a),  32'h0);
    check_output("reset_pe",    32'(pe_a),   32'h0);
    check_output("reset_fe",    32'(fe_a),   32'h0);
    check_output("reset_busy",  32'(busy_a), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_a(8'hA5, 1'b1);
    check_output("a5_pulses",     32'(pulses_a),     32'd1);
    check_output("a5_data",       32'(data_a),       32'hA5);
    check_output("a5_pe",         32'(pe_a),         32'h0);
    check_output("a5_fe",         32'(fe_a),         32'h0);
    check_output("a5_busy_after", 32'(busy_after_a), 32'h0);
    hold_a(1'b1, 10);

    hold_a(1'b0, 3);
    hold_a(1'b1, 1);
    check_output("glitch_busy_in_start", 32'(busy_a), 32'h1);
    hold_a(1'b1, 20);
    check_output("glitch_busy_idle", 32'(busy_a),   32'h0);
    check_output("glitch_pulses",    32'(pulses_a), 32'd1);
    check_output("glitch_data",      32'(data_a),   32'hA5);

    send_a(8'h3C, 1'b0);
    hold_a(1'b0, 20);
    check_output("break_busy_wait", 32'(busy_a),   32'h1);
    check_output("break_pulses",    32'(pulses_a), 32'd2);
    check_output("break_data",      32'(data_a),   32'h3C);
    check_output("break_fe",        32'(fe_a),     32'h1);
    check_output("break_pe",        32'(pe_a),     32'h0);
    hold_a(1'b1, 20);
    check_output("break_release_busy",   32'(busy_a),   32'h0);
    check_output("break_release_pulses", 32'(pulses_a), 32'd2);

    hold_a(1'b0, 10);
    hold_a(1'b1, 35);
    check_output("midframe_busy", 32'(busy_a), 32'h1);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_data", 32'(data_a), 32'h0);
    check_output("rst_irq",  32'(irq_a),  32'h0);
    check_output("rst_pe",   32'(pe_a),   32'h0);
    check_output("rst_fe",   32'(fe_a),   32'h0);
    check_output("rst_busy", 32'(busy_a), 32'h0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send_a(8'h81, 1'b1);
    check_output("r81_pulses", 32'(pulses_a), 32'd3);
    check_output("r81_data",   32'(data_a),   32'h81);
    check_output("r81_fe",     32'(fe_a),     32'h0);
    hold_a(1'b1, 10);

    send_a(8'h55, 1'b1);
    check_output("b2b_first_data", 32'(data_a), 32'h55);
    send_a(8'hAA, 1'b1);
    check_output("b2b_pulses",  32'(pulses_a),                    32'd5);
    check_output("b2b_data",    32'(data_a),                      32'hAA);
    check_output("b2b_spacing", 32'(last_pulse_a - prev_pulse_a), 32'd100);
    check_output("b2b_fe",      32'(fe_a),                        32'h0);
    hold_a(1'b1, 10);

    send_p(8'h07, 1'b1);
    check_output("par_ok_pulses", 32'(pulses_p), 32'd1);
    check_output("par_ok_data",   32'(data_p),   32'h07);
    check_output("par_ok_pe",     32'(pe_p),     32'h0);
    check_output("par_ok_fe",     32'(fe_p),     32'h0);
    hold_p(1'b1, 10);
    send_p(8'h07, 1'b0);
    check_output("par_bad_pulses", 32'(pulses_p), 32'd2);
    check_output("par_bad_data",   32'(data_p),   32'h07);
    check_output("par_bad_pe",     32'(pe_p),     32'h1);
    check_output("par_bad_fe",     32'(fe_p),     32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the P03 UART: oversamples the line `rx` with the system clock and deframes start, data, optional parity and stop bits. It presents the received word on `rx_data` and signals each completed frame with a one-cycle `rx_interrupt` pulse. That pulse feeds `interrupt_rgstr`, which holds the flag until software clears it. The block sits directly upstream of `interrupt_rgstr` and the RX data register.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz (DE2-115).
- `BAUD`, 115200: line rate in bit/s.
- `DATA_WIDTH`, 8: data bits per frame, legal range 5–9.
- `PARITY_EN`, 0: 1 inserts one parity bit after the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `rx`  in  1  serial line, idle high, asynchronous to `clk`
- `rx_data`  out  DATA_WIDTH  last received word, LSB first on the line
- `rx_interrupt`  out  1  one-cycle pulse per completed frame
- `parity_error`  out  1  parity mismatch on the last frame
- `frame_error`  out  1  stop bit sampled low on the last frame
- `busy`  out  1  high while a frame is being received

## Operation
- Derived constants:
  - BIT_CYCLES = CLK_FREQ/BAUD, integer division; must be ≥ 4.
  - HALF = BIT_CYCLES/2.
- Counter width is $clog2(BIT_CYCLES).
- Synchronizer: two flops on `rx`, both reset to 1. All logic uses the synchronized signal `rx_s`.
- FSM states:
  - IDLE: `rx_s`=0 → START, counter cleared.
  - START: at counter = HALF-1, sample `rx_s`. If 0 → DATA with the counter cleared. If 1, it is a glitch → IDLE, no pulse, no flag change.
  - DATA: at counter = BIT_CYCLES-1, sample one bit and shift it in LSB first. After DATA_WIDTH bits → PARITY if PARITY_EN, else STOP.
  - PARITY: sample at BIT_CYCLES-1. Error when the XOR of data and the parity bit is not PARITY_ODD. → STOP.
  - STOP: sample at BIT_CYCLES-1, then:
    - Load `rx_data`, `parity_error` and `frame_error` (frame_error = ~sample).
    - Pulse `rx_interrupt`.
    - If the sample is 1 → IDLE. If 0 → WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then → IDLE. A held break line yields exactly one frame.
- Counter: reset to 0 on every sample and on every state entry from IDLE.
- `busy` = (state ≠ IDLE).
- Outputs `rx_data`, `parity_error` and `frame_error` hold their value until the next completed frame. A START glitch does not change them.
- A pulse is issued even on an erroneous frame. Error flags are valid in the same cycle as the pulse.
- Reset mid-frame: FSM → IDLE and the partial word is discarded. When `rst` releases with `rx` low, the next falling edge is not required; a low line starts START immediately.

## Timing
- Reset values: `rx_data`=0, `rx_interrupt`=0, `parity_error`=0, `frame_error`=0, `busy`=0, state IDLE.
- Input latency: 2 cycles, from `rx` to `rx_s`.
- Sample points after the START entry:
  - Start bit: HALF.
  - Data bit k (k = 0..DATA_WIDTH-1): HALF + (k+1)·BIT_CYCLES.
- Outputs are registered. `rx_interrupt` is high during the cycle after the stop-bit sample, exactly 1 cycle wide.
- Back-to-back frames: returning to IDLE at mid-stop-bit permits a start edge right after the stop bit with no lost frame. Minimum pulse spacing is (DATA_WIDTH+2+PARITY_EN)·BIT_CYCLES cycles.

## Structure
- `uart_pkg` holds:
  - Typedef `uart_rx_state_e` (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH).
  - Default constants `UART_CLK_FREQ`, `UART_BAUD`, `UART_DATA_WIDTH`.
  - Function `bit_cycles(clk_freq, baud)`.
- One sub-module: `uart_rx_sync`, a 2-flop synchronizer with reset value 1.
- Counter, shift register and FSM live in `uart_rx`.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD=100_000, giving BIT_CYCLES=10 and HALF=5.
- 8N1, send 0xA5 → `rx_data`=0xA5, one pulse, both errors 0, `busy` low 1 cycle after the pulse.
- Drive `rx` low for 3 cycles in IDLE → no pulse, `rx_data` unchanged, state back to IDLE.
- Send 0x3C with the stop bit 0 and the line held low for 30 cycles → one pulse, `rx_data`=0x3C, `frame_error`=1. No second pulse until the line goes high and a new frame is sent.
- PARITY_EN=1 with even parity: send 0x07 with parity 1 → `parity_error`=0. Send 0x07 with parity 0 → `parity_error`=1.
- 0x55 then 0xAA with zero idle gap → two pulses 100 cycles apart, data correct, no errors.
- Assert `rst` during data bit 3, release, send 0x81 → all outputs at reset values during reset, then `rx_data`=0x81 with one pulse.
